sipo_deser_align: RTL and testbench
===================================

SIPO_DESER_ALIGN -- requirements
Module: sipo_deser_align

Interface
REQ-001 Parameter WIDTH, default 10: deserialized word width, legal range 4..32.
REQ-002 Parameter LSB_FIRST, default 1: 1 = first received bit lands in parallel_out[0]; 0 = first received bit lands in parallel_out[WIDTH-1].
REQ-003 Parameter ALIGN_EN, default 1: 1 = comma-based word alignment; 0 = free-running framing from reset.
REQ-004 Parameter COMMA_P, default 10'h17C: K28.5 RD- pattern, expressed in parallel_out bit order.
REQ-005 Parameter COMMA_N, default 10'h283: K28.5 RD+ pattern, expressed in parallel_out bit order.
REQ-006 Parameter MISS_LIMIT, default 2: consecutive misaligned commas that force loss of lock, legal range 1..15.
REQ-007 Port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-008 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port serial_in, input, 1 bit: serial data bit.
REQ-010 Port bit_valid, input, 1 bit: serial_in is sampled only when this is 1.
REQ-011 Port realign, input, 1 bit: single-cycle request to drop lock and re-hunt.
REQ-012 Port parallel_out, output, WIDTH bits: last framed word, registered.
REQ-013 Port word_valid, output, 1 bit: single-cycle pulse marking a new parallel_out.
REQ-014 Port is_comma, output, 1 bit: parallel_out equals COMMA_P or COMMA_N; qualified by word_valid.
REQ-015 Port locked, output, 1 bit: word boundary established.
REQ-016 Port align_err, output, 1 bit: single-cycle pulse when a comma is found at a misaligned offset.

Function
REQ-017 The shift window SHALL shift only on edges with bit_valid=1: LSB_FIRST=1 gives {serial_in, win[W-1:1]}; LSB_FIRST=0 gives {win[W-2:0], serial_in}.
REQ-018 Comma match SHALL be evaluated on the next window value, i.e. including the bit sampled on the current edge.
REQ-019 A bit counter of width $clog2(WIDTH) SHALL count valid bits 0..WIDTH-1 and wrap to 0; a word boundary is the edge on which the counter equals WIDTH-1.
REQ-020 On a boundary edge while locked, parallel_out SHALL load the next window and word_valid/is_comma SHALL be registered, so they are visible the cycle after the last bit is sampled (latency 1 cycle).
REQ-021 word_valid SHALL be 1 for exactly one cycle per word and SHALL be 0 in all other cycles; parallel_out SHALL hold its value between words.
REQ-022 With ALIGN_EN=0, locked SHALL be constant 1 after reset, framing SHALL start at the first valid bit after reset, and realign and align_err SHALL be inert (align_err held 0).
REQ-023 With ALIGN_EN=1, the FSM SHALL have two states, HUNT and LOCKED; reset enters HUNT.
REQ-024 In HUNT: no word_valid; on the first comma match, emit word_valid with is_comma=1, clear the counter, enter LOCKED, and set locked=1 in the same registered update.
REQ-025 In LOCKED, a comma on a boundary edge SHALL clear the miss counter.
REQ-026 In LOCKED, a comma on a non-boundary edge SHALL pulse align_err and increment the miss counter.
REQ-027 When the miss counter reaches MISS_LIMIT, the block SHALL enter HUNT, set locked=0, and clear the miss counter.
REQ-028 realign=1 SHALL force HUNT, locked=0 and a cleared miss counter on that edge, with priority over any simultaneous boundary or comma event, and SHALL suppress word_valid on that edge.
REQ-029 While bit_valid=0, state, counters and outputs other than the pulses SHALL hold.

Reset
REQ-030 On reset_n=0, asynchronously: window, parallel_out, bit counter and miss counter = 0; word_valid, is_comma and align_err = 0; locked = 0 (or 1 when ALIGN_EN=0); FSM = HUNT.
REQ-031 Reset mid-word SHALL discard partial bits; framing restarts from the first valid bit after reset_n rises.

Structure
REQ-032 A shared package/include serdes_pkg SHALL hold the K28.5 constants (10'h17C, 10'h283) and the HUNT/LOCKED state encoding.
REQ-033 The shift window SHALL be a sub-module sipo_shift_core (parameters WIDTH and LSB_FIRST; ports clk, reset_n, bit_valid, serial_in, window); FSM, counters and comparison stay in the top.

Verification
REQ-034 ALIGN_EN=0: shift 10'h2A5 LSB-first from reset -> one word_valid cycle after the 10th bit, parallel_out=10'h2A5, is_comma=0.
REQ-035 ALIGN_EN=1: 3 junk bits, then 10'h17C, then 10'h2A5 -> word_valid with parallel_out=10'h17C, is_comma=1, locked=1; next word 10'h2A5.
REQ-036 Locked, bit_valid deasserted for random gaps inside words -> same words and boundaries as the gapless run; no extra word_valid.
REQ-037 Locked, insert a 1-bit slip, then send commas -> align_err pulses twice, locked falls after the 2nd miss, relock on the next comma at the new offset.
REQ-038 realign pulse coincident with a boundary -> no word_valid, locked=0 next cycle, relock only on the next comma.
REQ-039 reset_n low after 5 bits of a word -> all outputs 0 immediately; the following 10'h283 is framed correctly in HUNT.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared SerDes constants: K28.5 comma patterns and the word-alignment FSM encoding.
package serdes_pkg;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  // Miss counter is sized for the largest legal MISS_LIMIT (15).
  localparam int MISS_W = 4;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_e;

endpackage

// File: rtl/sipo_shift_core.sv
// Serial-in shift window: advances one bit per qualified edge, in either bit order.
module sipo_shift_core #(
  parameter int WIDTH     = 10,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_valid,
  input  logic             serial_in,
  output logic [WIDTH-1:0] window
);

  logic [WIDTH-1:0] r_window;
  logic [WIDTH-1:0] w_window_nxt;

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign w_window_nxt = {serial_in, r_window[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_window_nxt = {r_window[WIDTH-2:0], serial_in};
    end
  endgenerate

  // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_window <= '0;
    end else if (bit_valid) begin
      r_window <= w_window_nxt;
    end
  end

  assign window = r_window;

endmodule

// File: rtl/sipo_deser_align.sv
// Serial-to-parallel deserializer with K28.5 comma-based word alignment and lock tracking.
module sipo_deser_align
  import serdes_pkg::*;
#(
  parameter int               WIDTH      = 10,
  parameter int               LSB_FIRST  = 1,
  parameter int               ALIGN_EN   = 1,
  parameter logic [WIDTH-1:0] COMMA_P    = WIDTH'(K28_5_RDN),
  parameter logic [WIDTH-1:0] COMMA_N    = WIDTH'(K28_5_RDP),
  parameter int               MISS_LIMIT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             realign,
  output logic [WIDTH-1:0] parallel_out,
  output logic             word_valid,
  output logic             is_comma,
  output logic             locked,
  output logic             align_err
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
  localparam logic             LOCK_RST = (ALIGN_EN == 0);

  logic [WIDTH-1:0]  w_window;
  logic [WIDTH-1:0]  w_next_win;
  logic              w_comma;
  logic              w_boundary;

  align_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_cnt_nxt;
  logic [MISS_W-1:0] r_miss_cnt, w_miss_nxt;
  logic [WIDTH-1:0]  r_parallel;
  logic              r_word_valid, r_is_comma, r_locked, r_align_err;
  logic              w_load, w_align_err_nxt, w_locked_nxt;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .window    (w_window)
  );

  // Comparison looks at the window as it will be after this edge, so a comma is
  // recognised on the same edge that samples its last bit.
  generate
    if (LSB_FIRST != 0) begin : g_next_lsb
      assign w_next_win = {serial_in, w_window[WIDTH-1:1]};
    end else begin : g_next_msb
      assign w_next_win = {w_window[WIDTH-2:0], serial_in};
    end
  endgenerate

  assign w_comma    = bit_valid && ((w_next_win == COMMA_P) || (w_next_win == COMMA_N));
  assign w_boundary = bit_valid && (r_bit_cnt == CNT_LAST);

  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_bit_cnt;
    w_miss_nxt      = r_miss_cnt;
    w_load          = 1'b0;
    w_align_err_nxt = 1'b0;

    if (ALIGN_EN == 0) begin
      if (bit_valid) begin
        w_load    = w_boundary;
        w_cnt_nxt = w_boundary ? '0 : CNT_W'(r_bit_cnt + 1'b1);
      end
    end else if (realign) begin
      w_state_nxt = ST_HUNT;
      w_cnt_nxt   = '0;
      w_miss_nxt  = '0;
    end else if (bit_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (w_comma) begin
            w_load      = 1'b1;
            w_cnt_nxt   = '0;
            w_miss_nxt  = '0;
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_boundary) begin
            w_load    = 1'b1;
            w_cnt_nxt = '0;
            if (w_comma) w_miss_nxt = '0;
          end else begin
            w_cnt_nxt = CNT_W'(r_bit_cnt + 1'b1);
            if (w_comma) begin
              w_align_err_nxt = 1'b1;
              if (r_miss_cnt >= MISS_LAST) begin
                w_state_nxt = ST_HUNT;
                w_cnt_nxt   = '0;
                w_miss_nxt  = '0;
              end else begin
                w_miss_nxt = MISS_W'(r_miss_cnt + 1'b1);
              end
            end
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end

    w_locked_nxt = (ALIGN_EN == 0) ? 1'b1 : (w_state_nxt == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_HUNT;
      r_bit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_parallel   <= '0;
      r_word_valid <= 1'b0;
      r_is_comma   <= 1'b0;
      r_locked     <= LOCK_RST;
      r_align_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_cnt_nxt;
      r_miss_cnt   <= w_miss_nxt;
      r_word_valid <= w_load;
      r_align_err  <= w_align_err_nxt;
      r_locked     <= w_locked_nxt;
      if (w_load) begin
        r_parallel <= w_next_win;
        r_is_comma <= w_comma;
      end
    end
  end

  assign parallel_out = r_parallel;
  assign word_valid   = r_word_valid;
  assign is_comma     = r_is_comma;
  assign locked       = r_locked;
  assign align_err    = r_align_err;

endmodule

// File: tb/tb_sipo_deser_align.sv
// Scoreboard bench: an aligning instance and a free-running instance share the serial stimulus.
module tb_sipo_deser_align;

  typedef struct {
    logic [9:0] data;
    logic       comma;
  } exp_word_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       serial_in;
  logic       bit_valid;
  logic       realign;

  logic [9:0] a_par, f_par;
  logic       a_wv, a_isc, a_lock, a_aerr;
  logic       f_wv, f_isc, f_lock, f_aerr;

  exp_word_t  q_a[$];
  exp_word_t  q_f[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_aerr   = 0;
  bit         free_chk = 1'b0;

  always #5 clk = ~clk;

  sipo_deser_align #(.ALIGN_EN(1)) u_align (
    .clk          (clk),
    .reset_n      (reset_n),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .realign      (realign),
    .parallel_out (a_par),
    .word_valid   (a_wv),
    .is_comma     (a_isc),
    .locked       (a_lock),
    .align_err    (a_aerr)
  );

  sipo_deser_align #(.ALIGN_EN(0)) u_free (
    .clk          (clk),
    .reset_n      (reset_n),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .realign      (realign),
    .parallel_out (f_par),
    .word_valid   (f_wv),
    .is_comma     (f_isc),
    .locked       (f_lock),
    .align_err    (f_aerr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Monitor on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (a_wv) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_word", {31'd0, a_wv}, 32'd0);
      end else begin
        exp_word_t e;
        e = q_a.pop_front();
        check("a_word", {22'd0, a_par}, {22'd0, e.data});
        check("a_is_comma", {31'd0, a_isc}, {31'd0, e.comma});
      end
    end
    if (a_aerr) n_aerr++;
    if (f_aerr) check("f_align_err", {31'd0, f_aerr}, 32'd0);
    if (free_chk && f_wv) begin
      if (q_f.size() == 0) begin
        check("f_unexpected_word", {31'd0, f_wv}, 32'd0);
      end else begin
        exp_word_t e;
        e = q_f.pop_front();
        check("f_word", {22'd0, f_par}, {22'd0, e.data});
        check("f_is_comma", {31'd0, f_isc}, {31'd0, e.comma});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic rl);
    serial_in = b;
    bit_valid = 1'b1;
    realign   = rl;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    realign   = 1'b0;
    serial_in = 1'b0;
  endtask

  // Sends a word LSB first; optional random idle gaps and a realign on the last bit.
  task automatic send_word(input logic [9:0] w, input int max_gap, input logic rl_last);
    for (int i = 0; i < 10; i++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_bit(w[i], (i == 9) ? rl_last : 1'b0);
    end
  endtask

  task automatic push_a(input logic [9:0] d, input logic c);
    exp_word_t e;
    e.data  = d;
    e.comma = c;
    q_a.push_back(e);
  endtask

  task automatic push_f(input logic [9:0] d, input logic c);
    exp_word_t e;
    e.data  = d;
    e.comma = c;
    q_f.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int aerr0;
    logic [9:0] gap_words [5];
    gap_words = '{10'h155, 10'h0CC, 10'h333, 10'h17C, 10'h2A5};

    reset_n   = 1'b0;
    serial_in = 1'b0;
    bit_valid = 1'b0;
    realign   = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);

    // Reset state of both instances.
    check("rst_a_locked", {31'd0, a_lock}, 32'd0);
    check("rst_f_locked", {31'd0, f_lock}, 32'd1);
    check("rst_a_par", {22'd0, a_par}, 32'd0);
    check("rst_a_wv", {31'd0, a_wv}, 32'd0);

    // Free-running framing from the first valid bit.
    free_chk = 1'b1;
    push_f(10'h2A5, 1'b0);
    send_word(10'h2A5, 0, 1'b0);
    idle(3);
    check("f_queue_empty", q_f.size(), 32'd0);
    free_chk = 1'b0;

    // Junk bits, then comma lock, then a data word.
    do_reset();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("hunt_locked", {31'd0, a_lock}, 32'd0);
    push_a(10'h17C, 1'b1);
    send_word(10'h17C, 0, 1'b0);
    check("lock_after_comma", {31'd0, a_lock}, 32'd1);
    push_a(10'h2A5, 1'b0);
    send_word(10'h2A5, 0, 1'b0);
    idle(2);
    check("lock_queue_empty", q_a.size(), 32'd0);

    // Random bit_valid gaps inside words must not change framing.
    aerr0 = n_aerr;
    foreach (gap_words[i]) begin
      push_a(gap_words[i], gap_words[i] == 10'h17C);
      send_word(gap_words[i], 3, 1'b0);
    end
    idle(3);
    check("gap_queue_empty", q_a.size(), 32'd0);
    check("gap_no_align_err", n_aerr - aerr0, 32'd0);
    check("gap_locked", {31'd0, a_lock}, 32'd1);

    // One-bit slip: two misaligned commas drop lock, third relocks.
    aerr0 = n_aerr;
    send_bit(1'b0, 1'b0);
    push_a(10'h2F8, 1'b0);
    send_word(10'h17C, 0, 1'b0);
    check("slip_still_locked", {31'd0, a_lock}, 32'd1);
    push_a(10'h2F8, 1'b0);
    send_word(10'h17C, 0, 1'b0);
    check("slip_lost_lock", {31'd0, a_lock}, 32'd0);
    idle(1);
    check("slip_align_errs", n_aerr - aerr0, 32'd2);
    push_a(10'h17C, 1'b1);
    send_word(10'h17C, 0, 1'b0);
    check("slip_relocked", {31'd0, a_lock}, 32'd1);
    push_a(10'h2A5, 1'b0);
    send_word(10'h2A5, 0, 1'b0);
    idle(2);
    check("slip_queue_empty", q_a.size(), 32'd0);

    // Realign on a boundary edge: word suppressed, lock dropped until next comma.
    send_word(10'h155, 0, 1'b1);
    check("realign_no_wv", {31'd0, a_wv}, 32'd0);
    check("realign_unlocked", {31'd0, a_lock}, 32'd0);
    send_word(10'h2A5, 0, 1'b0);
    check("realign_still_hunt", {31'd0, a_lock}, 32'd0);
    push_a(10'h17C, 1'b1);
    send_word(10'h17C, 0, 1'b0);
    check("realign_relocked", {31'd0, a_lock}, 32'd1);
    idle(2);

    // Asynchronous reset mid-word, then an RD+ comma framed from scratch.
    for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_a_par", {22'd0, a_par}, 32'd0);
    check("async_a_locked", {31'd0, a_lock}, 32'd0);
    check("async_a_isc", {31'd0, a_isc}, 32'd0);
    check("async_f_locked", {31'd0, f_lock}, 32'd1);
    check("async_f_par", {22'd0, f_par}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    free_chk = 1'b1;
    push_a(10'h283, 1'b1);
    push_f(10'h283, 1'b1);
    send_word(10'h283, 0, 1'b0);
    check("rdp_locked", {31'd0, a_lock}, 32'd1);
    idle(3);
    check("rdp_a_queue_empty", q_a.size(), 32'd0);
    check("rdp_f_queue_empty", q_f.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
